// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding
// and the default parameter values used by pc_unit and pc_ras.
package pc_pkg;

    localparam int unsigned PC_W_DEF      = 5;
    localparam int unsigned RESET_VEC_DEF = 0;
    localparam int unsigned STEP_DEF      = 1;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        SEQ  = 3'd1,
        BR   = 3'd2,
        JMP  = 3'd3,
        CALL = 3'd4,
        RET  = 3'd5
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. When it is full, a push overwrites the oldest entry.
// Overflow and underflow produce a one-cycle registered err pulse.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty,
    output logic            err
);

    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   top_ptr_q, top_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic [PW-1:0]   ptr_inc, ptr_dec;
    logic            do_push, do_pop;

    // Pointer arithmetic wraps explicitly, so RAS_DEPTH need not be a power of two.
    assign ptr_inc = (top_ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : top_ptr_q + 1'b1;
    assign ptr_dec = (top_ptr_q == '0) ? PW'(RAS_DEPTH - 1) : top_ptr_q - 1'b1;

    assign full  = (count_q == CW'(RAS_DEPTH));
    assign empty = (count_q == '0);
    assign top   = mem_q[top_ptr_q];
    assign err   = err_q;

    // Pop wins if both are asserted; the owner never asserts both.
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~pop;

    always_comb begin
        top_ptr_d = top_ptr_q;
        count_d   = count_q;
        err_d     = 1'b0;
        if (pop) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                top_ptr_d = ptr_dec;
                count_d   = count_q - 1'b1;
            end
        end else if (push) begin
            top_ptr_d = ptr_inc;
            if (full) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_ptr_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            top_ptr_q <= top_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    // Storage is not reset; the count alone determines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[ptr_inc] <= push_data;
        end
    end

    logic unused_ok;
    assign unused_ok = do_pop;

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter. Requests are prioritised (stall, return, call, jump,
// relative branch, sequential), and calls/returns use a return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned RESET_VEC = RESET_VEC_DEF,
    parameter int unsigned STEP      = STEP_DEF,
    parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            br_en,
    input  logic [PC_W-1:0] br_off,
    input  logic            jmp_en,
    input  logic            call_en,
    input  logic [PC_W-1:0] jmp_tgt,
    input  logic            ret_en,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] ipc,
    output logic            ipc_valid,
    output logic            ras_full,
    output logic            ras_empty,
    output logic            ras_err
);

    pc_sel_e         sel;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ipc_q, ipc_d;
    logic            ipc_valid_q, ipc_valid_d;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] ras_top;
    logic            ras_push, ras_pop;
    logic            ras_full_w, ras_empty_w, ras_err_w;

    assign seq_pc = pc_q + PC_W'(STEP);

    always_comb begin
        sel = SEQ;
        if (stall)        sel = HOLD;
        else if (ret_en)  sel = RET;
        else if (call_en) sel = CALL;
        else if (jmp_en)  sel = JMP;
        else if (br_en)   sel = BR;
    end

    // br_off has the same width as pc, so adding it modulo 2^PC_W already
    // gives the sign-extended result.
    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            HOLD:     pc_d = pc_q;
            SEQ:      pc_d = seq_pc;
            BR:       pc_d = pc_q + br_off;
            JMP,
            CALL:     pc_d = jmp_tgt;
            RET:      pc_d = ras_empty_w ? seq_pc : ras_top;
            default:  pc_d = pc_q;
        endcase
    end

    always_comb begin
        ipc_d       = ipc_q;
        ipc_valid_d = ipc_valid_q & ~flush;
        if (sel != HOLD) begin
            ipc_d       = pc_q;
            ipc_valid_d = ~flush;
        end
    end

    assign ras_push = (sel == CALL);
    assign ras_pop  = (sel == RET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= PC_W'(RESET_VEC);
            ipc_q       <= '0;
            ipc_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ipc_q       <= ipc_d;
            ipc_valid_q <= ipc_valid_d;
        end
    end

    pc_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .full      (ras_full_w),
        .empty     (ras_empty_w),
        .err       (ras_err_w)
    );

    assign pc        = pc_q;
    assign ipc       = ipc_q;
    assign ipc_valid = ipc_valid_q;
    assign ras_full  = ras_full_w;
    assign ras_empty = ras_empty_w;
    assign ras_err   = ras_err_w;

endmodule
